alsu_out_serializer: RTL and testbench

Downstream stage of the ALSU. It captures 6-bit ALSU results, each tagged with an error flag taken from the ALSU invalid indication (OR of its leds). Results are buffered in a small FIFO and shifted out on a single-wire framed serial line, so board-level results can be logged by an external receiver. The block has one clock and a synchronous, active-low reset.

---
 rtl/alsu_out_serializer_pkg.sv | 27 ++
 rtl/alsu_out_serializer_if.sv | 25 ++
 rtl/alsu_out_serializer_sync_fifo.sv | 56 +++++
 rtl/alsu_out_serializer.sv | 135 +++++++++++++
 tb/tb_alsu_out_serializer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alsu_out_serializer_pkg.sv
// Shared types and constants for the ALSU output serializer.
// Holds the data width, frame length, tx FSM states and FIFO entry type.
package alsu_pkg;

  localparam int ALSU_DW    = 6;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ERR,
    PAR,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic               err;
    logic [ALSU_DW-1:0] data;
  } entry_t;

  // Even parity over the whole entry (err and data).
  function automatic logic even_parity(entry_t e);
    return ^e;
  endfunction

endpackage

// File: rtl/alsu_out_serializer_if.sv
// Sample-in handshake between the ALSU and the output serializer.
// master drives in_valid/in_data/in_err; slave returns in_ready.
interface alsu_out_serializer_if;
  import alsu_pkg::*;

  logic               in_valid;
  logic [ALSU_DW-1:0] in_data;
  logic               in_err;
  logic               in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_err,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_err,
    output in_ready
  );

endinterface

// File: rtl/alsu_out_serializer_sync_fifo.sv
// Single-clock FIFO with occupancy count; writes while full are dropped.
// Ports: clk, rst (sync, active-low), push/wr_data, pop/rd_data, full, empty, count.
module alsu_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push)
      mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/alsu_out_serializer.sv
// Buffers tagged ALSU results and shifts them out as 10-bit framed serial words.
// Ports: clk, rst (sync, active-low), up (sample handshake), tx, busy, overflow, count.
module alsu_out_serializer #(
  parameter int DEPTH    = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alsu_out_serializer_if.slave   up,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);
  import alsu_pkg::*;

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(ALSU_DW - 1);

  tx_state_t          state;
  logic [BW-1:0]      baud;
  logic [2:0]         bitcnt;
  logic [ALSU_DW-1:0] shift;
  logic               err_q;
  logic               par_q;
  entry_t             wr_entry;
  entry_t             head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               bit_end;

  assign wr_entry    = {up.in_err, up.in_data};
  assign up.in_ready = !full;
  assign pop         = (state == IDLE) && !empty;
  assign bit_end     = (baud == BAUD_LAST);

  alsu_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (up.in_valid),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      overflow <= 1'b0;
    else if (up.in_valid && full)
      overflow <= 1'b1;
  end

  // tx and busy are registered alongside the state so the
  // line never glitches on a state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      tx     <= 1'b1;
      busy   <= 1'b0;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
      err_q  <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      if (state != IDLE)
        baud <= bit_end ? '0 : baud + BW'(1);
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (!empty) begin
            shift <= head.data;
            err_q <= head.err;
            par_q <= even_parity(head);
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx     <= shift[0];
            bitcnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bitcnt == BIT_LAST) begin
              state <= ERR;
              tx    <= err_q;
            end else begin
              shift  <= shift >> 1;
              tx     <= shift[1];
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end
        ERR: begin
          if (bit_end) begin
            state <= PAR;
            tx    <= par_q;
          end
        end
        PAR: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_out_serializer.sv
// Self-checking bench for alsu_out_serializer (DEPTH=8, BAUD_DIV=4).
// Frame-position reference model plus table vectors and corner sequences.
module tb_alsu_out_serializer;
  import alsu_pkg::*;

  localparam int DEPTH = 8;
  localparam int B     = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FLEN  = FRAME_BITS * B;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  alsu_out_serializer_if bus();

  alsu_out_serializer #(
    .DEPTH    (DEPTH),
    .BAUD_DIV (B)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (bus),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .count    (count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [6:0] mq[$];
  int         m_pos = -1;
  bit         m_bits[FRAME_BITS];
  bit         m_ovf = 1'b0;

  typedef struct {
    logic [5:0] d;
    logic       e;
    bit         f[FRAME_BITS];
  } vec_t;

  vec_t tbl[4];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Model: a frame is a position counter 0..FLEN-1 over a
  // list of 10 bits; a pop starts one when idle and queued.
  function automatic void model_edge(logic r, logic v,
                                     logic [5:0] d, logic e);
    bit         do_pop;
    bit         room;
    logic [6:0] h;
    if (!r) begin
      mq.delete();
      m_pos = -1;
      m_ovf = 1'b0;
      return;
    end
    do_pop = (m_pos < 0) && (mq.size() > 0);
    room   = mq.size() < DEPTH;
    if (v && !room)
      m_ovf = 1'b1;
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == FLEN)
        m_pos = -1;
    end
    if (do_pop) begin
      h = mq.pop_front();
      m_bits[0] = 1'b0;
      for (int i = 0; i < 6; i++)
        m_bits[1+i] = h[i];
      m_bits[7] = h[6];
      m_bits[8] = ^h;
      m_bits[9] = 1'b1;
      m_pos = 0;
    end
    if (v && room)
      mq.push_back({e, d});
  endfunction

  task automatic step(logic v, logic [5:0] d, logic e);
    bit exp_tx;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_err   = e;
    @(posedge clk);
    model_edge(rst, v, d, e);
    cyc++;
    @(negedge clk);
    exp_tx = (m_pos < 0) ? 1'b1 : m_bits[m_pos / B];
    check("tx", tx, exp_tx);
    check("busy", busy, m_pos >= 0);
    check("count", count, mq.size());
    check("in_ready", bus.in_ready, mq.size() < DEPTH);
    check("overflow", overflow, m_ovf);
  endtask

  initial begin
    bit prev_busy;
    int rises;
    int last_rise;
    int guard;

    tbl[0] = '{6'b101101, 1'b0, '{0,1,0,1,1,0,1,0,0,1}};
    tbl[1] = '{6'b000001, 1'b1, '{0,1,0,0,0,0,0,1,0,1}};
    tbl[2] = '{6'b111111, 1'b0, '{0,1,1,1,1,1,1,0,0,1}};
    tbl[3] = '{6'b000000, 1'b1, '{0,0,0,0,0,0,0,1,1,1}};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_err   = 1'b0;

    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    // Single frames against literal bit tables.
    for (int t = 0; t < 4; t++) begin
      step(1, tbl[t].d, tbl[t].e);
      for (int j = 0; j < FLEN + 2; j++) begin
        step(0, 0, 0);
        if (j < FLEN && (j % B) == B / 2)
          check("frame_bit", tx, tbl[t].f[j / B]);
        if (j == FLEN - 1)
          check("busy_last", busy, 1);
        if (j == FLEN)
          check("busy_drop", busy, 0);
      end
    end

    // Fill to full while the first frame runs.
    for (int k = 0; k < 10; k++) begin
      step(1, 6'(k), 1'b0);
      if (k == 8)
        check("in_ready_full", bus.in_ready, 0);
    end
    check("overflow_set", overflow, 1);
    rises     = 0;
    last_rise = -1;
    prev_busy = busy;
    for (int i = 0; i < 9 * (FLEN + 1); i++) begin
      step(0, 0, 0);
      if (busy && !prev_busy) begin
        if (last_rise >= 0)
          check("frame_period", cyc - last_rise, FLEN + 1);
        last_rise = cyc;
        rises++;
      end
      prev_busy = busy;
    end
    check("fill_frames", rises, 8);
    check("overflow_sticky", overflow, 1);

    // Push and pop on the same edge at count=3.
    for (int k = 0; k < 4; k++) step(1, 6'(20 + k), 1'(k));
    guard = 0;
    while (!(busy == 1'b0 && count == CW'(3)) && guard < 100) begin
      step(0, 0, 0);
      guard++;
    end
    check("pushpop_reach", guard < 100, 1);
    step(1, 6'h2a, 1'b1);
    check("count_pushpop", count, 3);
    check("busy_pushpop", busy, 1);
    for (int i = 0; i < 4 * (FLEN + 1) + 5; i++) step(0, 0, 0);

    // Reset in the middle of the DATA bits.
    for (int k = 0; k < 3; k++) step(1, 6'(40 + k), 1'b0);
    guard = 0;
    while (m_pos < 2 * B && guard < 50) begin
      step(0, 0, 0);
      guard++;
    end
    check("midframe_reach", guard < 50, 1);
    rst = 1'b0;
    step(1, 6'h3f, 1'b1);
    rst = 1'b1;
    check("rst_tx", tx, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 0);

    // Random traffic with bursts and rare resets.
    for (int i = 0; i < 4000; i++) begin
      bit v;
      v   = ((i / 300) % 3 == 1) ? ($urandom_range(0, 3) != 0)
                                 : ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
      step(v, 6'($urandom), 1'($urandom));
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
